// File: rtl/iir_inverse_serial_if.sv
`default_nettype none
// ============================================================================
// Module      : iir_inverse_serial_if
// Description : Sample-stream and status bundle for iir_inverse_serial.
// Revision    : 1.0 - initial release
// ============================================================================
interface iir_inverse_serial_if;
    logic               din_valid;
    logic signed [11:0] din;
    logic               dout_valid;
    logic signed [11:0] dout;
    logic               busy;
    logic               overrun;
    logic               overrun_clr;

    modport master (
        output din_valid, din, overrun_clr,
        input  dout_valid, dout, busy, overrun
    );

    modport slave (
        input  din_valid, din, overrun_clr,
        output dout_valid, dout, busy, overrun
    );
endinterface
`default_nettype wire

// File: rtl/iir_inverse_serial.sv
`default_nettype none
// ============================================================================
// Module      : iir_inverse_serial
// Description : 4th-order DF-I inverse IIR, A(z)/B(z) with B0=512, using one
//               time-multiplexed MAC (11 clocks per sample).
//               Define IIR_INV_SAT_EN to saturate the output instead of wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module iir_inverse_serial #(
    parameter logic signed [11:0] A0 = 12'sd512,
    parameter logic signed [11:0] A1 = 12'sd0,
    parameter logic signed [11:0] A2 = 12'sd0,
    parameter logic signed [11:0] A3 = 12'sd0,
    parameter logic signed [11:0] A4 = 12'sd0,
    parameter logic signed [11:0] B1 = 12'sd0,
    parameter logic signed [11:0] B2 = 12'sd0,
    parameter logic signed [11:0] B3 = 12'sd0,
    parameter logic signed [11:0] B4 = 12'sd0
) (
    input  wire logic            clk,
    input  wire logic            rst,
    iir_inverse_serial_if.slave  bus
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_MAC   = 2'd1;
    localparam logic [1:0] c_SCALE = 2'd2;
    localparam logic [3:0] c_KLAST = 4'd8;

    logic [1:0]         r_state;
    logic [3:0]         r_k;
    logic signed [27:0] r_acc;
    logic signed [11:0] r_x0, r_x1, r_x2, r_x3, r_x4;
    logic signed [11:0] r_y1, r_y2, r_y3, r_y4;
    logic signed [11:0] r_dout;
    logic               r_dout_valid;
    logic               r_overrun;

    logic signed [11:0] w_coef;
    logic signed [11:0] w_samp;
    logic signed [23:0] w_prod;
    logic signed [27:0] w_prod_ext;
    logic               w_sub;
    logic signed [11:0] w_result;
    logic               w_busy;

    assign w_busy = (r_state != c_IDLE);

    // Tap sequencer: k=0..4 numerator (add), k=5..8 feedback (subtract)
    always_comb begin
        w_coef = 12'sd0;
        w_samp = 12'sd0;
        case (r_k)
            4'd0:    begin w_coef = A0; w_samp = r_x0; end
            4'd1:    begin w_coef = A1; w_samp = r_x1; end
            4'd2:    begin w_coef = A2; w_samp = r_x2; end
            4'd3:    begin w_coef = A3; w_samp = r_x3; end
            4'd4:    begin w_coef = A4; w_samp = r_x4; end
            4'd5:    begin w_coef = B1; w_samp = r_y1; end
            4'd6:    begin w_coef = B2; w_samp = r_y2; end
            4'd7:    begin w_coef = B3; w_samp = r_y3; end
            4'd8:    begin w_coef = B4; w_samp = r_y4; end
            default: begin w_coef = 12'sd0; w_samp = 12'sd0; end
        endcase
    end

    assign w_prod     = $signed({{12{w_coef[11]}}, w_coef}) * $signed({{12{w_samp[11]}}, w_samp});
    assign w_prod_ext = $signed({{4{w_prod[23]}}, w_prod});
    assign w_sub      = (r_k > 4'd4);

`ifdef IIR_INV_SAT_EN
    logic signed [27:0] w_ydiv;
    assign w_ydiv = r_acc >>> 9;

    always_comb begin
        w_result = w_ydiv[11:0];
        if (w_ydiv > 28'sd2047)
            w_result = 12'sd2047;
        else if (w_ydiv < -28'sd2048)
            w_result = -12'sd2048;
    end
`else
    // Floor shift then wrap to 12 bits is just a bit-slice of the accumulator
    always_comb begin
        w_result = r_acc[20:9];
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= c_IDLE;
            r_k          <= 4'd0;
            r_acc        <= 28'sd0;
            r_x0         <= 12'sd0;
            r_x1         <= 12'sd0;
            r_x2         <= 12'sd0;
            r_x3         <= 12'sd0;
            r_x4         <= 12'sd0;
            r_y1         <= 12'sd0;
            r_y2         <= 12'sd0;
            r_y3         <= 12'sd0;
            r_y4         <= 12'sd0;
            r_dout       <= 12'sd0;
            r_dout_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_dout_valid <= 1'b0;

            if (bus.din_valid && w_busy)
                r_overrun <= 1'b1;
            else if (bus.overrun_clr)
                r_overrun <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    if (bus.din_valid) begin
                        r_x0    <= bus.din;
                        r_acc   <= 28'sd0;
                        r_k     <= 4'd0;
                        r_state <= c_MAC;
                    end
                end
                c_MAC: begin
                    r_acc <= w_sub ? (r_acc - w_prod_ext) : (r_acc + w_prod_ext);
                    if (r_k == c_KLAST)
                        r_state <= c_SCALE;
                    else
                        r_k <= r_k + 4'd1;
                end
                c_SCALE: begin
                    r_dout       <= w_result;
                    r_dout_valid <= 1'b1;
                    r_x4         <= r_x3;
                    r_x3         <= r_x2;
                    r_x2         <= r_x1;
                    r_x1         <= r_x0;
                    r_y4         <= r_y3;
                    r_y3         <= r_y2;
                    r_y2         <= r_y1;
                    r_y1         <= w_result;
                    r_state      <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.busy       = w_busy;
    assign bus.overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_iir_inverse_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_iir_inverse_serial
// Description : Scoreboard bench for iir_inverse_serial (three coefficient sets).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iir_inverse_serial;

`ifdef IIR_INV_SAT_EN
    localparam int c_OVF_EXP = 2047;
`else
    localparam int c_OVF_EXP = -1096;
`endif

    typedef struct {
        logic signed [11:0] val;
        int                 due;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    exp_t sbq [3][$];

    iir_inverse_serial_if if0();
    iir_inverse_serial_if if1();
    iir_inverse_serial_if if2();

    // u0: zero (A1=-410), u1: pole (B1=-256), u2: gain 2 for overflow
    iir_inverse_serial #(.A0(12'sd512), .A1(-12'sd410)) u0 (.clk(clk), .rst(rst), .bus(if0));
    iir_inverse_serial #(.A0(12'sd512), .B1(-12'sd256)) u1 (.clk(clk), .rst(rst), .bus(if1));
    iir_inverse_serial #(.A0(12'sd1024))                u2 (.clk(clk), .rst(rst), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic mon(input int idx, input logic signed [11:0] d);
        exp_t e;
        if (sbq[idx].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_dout u%0d: got %0d at cycle %0d expected no output", idx, d, cyc);
        end else begin
            e = sbq[idx].pop_front();
            check($sformatf("dout u%0d", idx), d, e.val);
            check($sformatf("latency u%0d", idx), cyc, e.due);
        end
    endtask

    always @(negedge clk) begin
        if (if0.dout_valid) mon(0, if0.dout);
        if (if1.dout_valid) mon(1, if1.dout);
        if (if2.dout_valid) mon(2, if2.dout);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds din_valid for one cycle; call just after a rising edge
    task automatic pulse(input int idx, input int v, input bit push, input int expv);
        case (idx)
            0: begin if0.din_valid = 1'b1; if0.din = 12'(v); end
            1: begin if1.din_valid = 1'b1; if1.din = 12'(v); end
            default: begin if2.din_valid = 1'b1; if2.din = 12'(v); end
        endcase
        if (push) sbq[idx].push_back('{12'(expv), cyc + 11});
        wait_cyc(1);
        if0.din_valid = 1'b0;
        if1.din_valid = 1'b0;
        if2.din_valid = 1'b0;
    endtask

    task automatic impulse_run();
        int exp_tab [3] = '{1000, -801, 0};
        int in_tab  [3] = '{1000, 0, 0};
        for (int i = 0; i < 3; i++) begin
            pulse(0, in_tab[i], 1'b1, exp_tab[i]);
            wait_cyc(10);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        if0.din_valid = 1'b0; if0.din = '0; if0.overrun_clr = 1'b0;
        if1.din_valid = 1'b0; if1.din = '0; if1.overrun_clr = 1'b0;
        if2.din_valid = 1'b0; if2.din = '0; if2.overrun_clr = 1'b0;
        wait_cyc(3);
        check("reset dout", if0.dout, 0);
        check("reset dout_valid", int'(if0.dout_valid), 0);
        check("reset busy", int'(if0.busy), 0);
        check("reset overrun", int'(if0.overrun), 0);
        rst = 1'b1;
        wait_cyc(1);

        // Zero impulse with busy window checks on the first sample
        pulse(0, 1000, 1'b1, 1000);
        check("busy T+1", int'(if0.busy), 1);
        wait_cyc(9);
        check("busy T+10", int'(if0.busy), 1);
        wait_cyc(1);
        check("busy T+11", int'(if0.busy), 0);
        pulse(0, 0, 1'b1, -801);
        wait_cyc(10);
        pulse(0, 0, 1'b1, 0);
        wait_cyc(10);

        // Pole decay, back-to-back samples
        begin
            int pole_exp [5] = '{1024, 512, 256, 128, 64};
            for (int i = 0; i < 5; i++) begin
                pulse(1, (i == 0) ? 1024 : 0, 1'b1, pole_exp[i]);
                wait_cyc(10);
            end
        end

        // Overflow: 1500*1024/512 = 3000
        pulse(2, 1500, 1'b1, c_OVF_EXP);
        wait_cyc(12);

        // Overrun at T+3 on the pole filter: (512*100 + 256*64) >>> 9 = 132
        pulse(1, 100, 1'b1, 132);
        wait_cyc(2);
        pulse(1, 50, 1'b0, 0);
        wait_cyc(8);
        check("overrun set", int'(if1.overrun), 1);
        check("overrun held dout", if1.dout, 132);
        if1.overrun_clr = 1'b1;
        wait_cyc(1);
        if1.overrun_clr = 1'b0;
        check("overrun cleared", int'(if1.overrun), 0);

        // Leave overrun set on u2 so reset must clear it
        pulse(2, 1500, 1'b1, c_OVF_EXP);
        wait_cyc(1);
        pulse(2, 7, 1'b0, 0);
        wait_cyc(12);
        check("overrun u2 set", int'(if2.overrun), 1);

        // Abort mid-computation at T+5, reset asserted between edges
        pulse(0, 1000, 1'b0, 0);
        wait_cyc(4);
        #1;
        rst = 1'b0;
        #1;
        check("async busy", int'(if0.busy), 0);
        check("async dout u1", if1.dout, 0);
        check("async dout u2", if2.dout, 0);
        check("async overrun u2", int'(if2.overrun), 0);
        check("async dout_valid", int'(if0.dout_valid), 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        wait_cyc(1);

        impulse_run();
        pulse(1, 1024, 1'b1, 1024);
        wait_cyc(15);

        check("queue empty u0", sbq[0].size(), 0);
        check("queue empty u1", sbq[1].size(), 0);
        check("queue empty u2", sbq[2].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
